// File: rtl/cp0_pkg.sv
// cp0_pkg: ExcCodes, Status bit indices and sequencer states shared by CP0 and its requesters.
package cp0_pkg;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BRK = 5'd9;
  localparam logic [4:0] EXC_TEQ = 5'd13;
  localparam int SR_IE  = 0;
  localparam int SR_SYS = 1;
  localparam int SR_BRK = 2;
  localparam int SR_TEQ = 3;
  localparam int SR_INT = 8;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXC  = 3'd1,
    ST_VEC  = 3'd2,
    ST_RET  = 3'd3,
    ST_RRD  = 3'd4
  } state_t;
endpackage

// File: rtl/cp0_exc_ctrl_irq_sync.sv
// irq_sync: two-flop synchronizer with a registered rising-edge pulse.
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
      rise <= s2 & ~s3;
    end
  end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: masks, prioritises and sequences exception/ERET requests towards CP0 and redirects fetch.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] dec_pc,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        is_eret,
  input  logic        teq_equal,
  input  logic        irq,
  input  logic [31:0] status,
  input  logic [31:0] epc_addr,
  output logic        exception,
  output logic [4:0]  cause,
  output logic [31:0] cp0_pc,
  output logic        eret,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        stall
);
  state_t st;
  logic irq_rise, irq_pend, ie, idle;
  logic take_eret, take_sys, take_brk, take_teq, take_int, take_exc;
  logic [4:0] code;
  logic unused_ok;
  assign unused_ok = ^{status[31:9], status[7:4]};
  irq_sync u_irq_sync (.clk(clk), .rst(rst), .irq(irq), .rise(irq_rise));
  always_comb begin
    idle = st == ST_IDLE;
    ie = idle & instr_valid & status[SR_IE];
    take_eret = idle & instr_valid & is_eret;
    take_sys = ie & status[SR_SYS] & is_syscall;
    take_brk = ie & status[SR_BRK] & is_break;
    take_teq = ie & status[SR_TEQ] & is_teq & teq_equal;
    // the fresh edge counts as pending so INT is not delayed a cycle by the pend register
    take_int = ie & status[SR_INT] & (irq_pend | irq_rise) & ~(take_eret | take_sys | take_brk | take_teq);
    take_exc = take_sys | take_brk | take_teq | take_int;
    code = take_sys ? EXC_SYS : take_brk ? EXC_BRK : take_teq ? EXC_TEQ : EXC_INT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= ST_IDLE;
      irq_pend <= 1'b0;
      exception <= 1'b0;
      cause <= 5'd0;
      cp0_pc <= 32'd0;
      eret <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_target <= 32'd0;
      stall <= 1'b0;
    end else begin
      irq_pend <= (irq_pend | irq_rise) & ~take_int;
      exception <= 1'b0;
      eret <= 1'b0;
      pc_redirect <= 1'b0;
      case (st)
        ST_IDLE:
          if (take_eret) begin
            st <= ST_RET;
            eret <= 1'b1;
            stall <= 1'b1;
          end else if (take_exc) begin
            st <= ST_EXC;
            exception <= 1'b1;
            cause <= code;
            cp0_pc <= dec_pc;
            stall <= 1'b1;
          end
        ST_EXC: begin
          st <= ST_VEC;
          pc_redirect <= 1'b1;
          redirect_target <= EXC_VECTOR;
        end
        ST_RET: begin
          st <= ST_RRD;
          pc_redirect <= 1'b1;
          redirect_target <= epc_addr;
        end
        default: begin
          st <= ST_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] VEC = 32'h0040_0004;
  logic clk = 0, rst = 0, instr_valid = 0, is_syscall = 0, is_break = 0, is_teq = 0, is_eret = 0;
  logic teq_equal = 0, irq = 0;
  logic [31:0] dec_pc = 0, status = 0, epc_addr = 0;
  logic exception, eret, pc_redirect, stall;
  logic [4:0] cause;
  logic [31:0] cp0_pc, redirect_target;
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  cause;
    logic [31:0] val;
  } ev_t;
  ev_t q[$];
  int n_chk = 0, n_fail = 0, ev_cnt = 0, stall_cyc = 0, cyc = 0, exc_cyc = 0, irq_cyc = 0, run = 0;
  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .dec_pc(dec_pc),
    .is_syscall(is_syscall), .is_break(is_break), .is_teq(is_teq), .is_eret(is_eret),
    .teq_equal(teq_equal), .irq(irq), .status(status), .epc_addr(epc_addr),
    .exception(exception), .cause(cause), .cp0_pc(cp0_pc), .eret(eret),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target), .stall(stall)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic pop(input logic [1:0] kind, input logic [4:0] c, input logic [31:0] v);
    ev_t e;
    ev_cnt++;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d cause %0d value %h, expected none", kind, c, v);
    end else begin
      e = q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == 2'd0) check("cause", 32'(c), 32'(e.cause));
      if (e.kind != 2'd1) check(e.kind == 2'd0 ? "cp0_pc" : "redirect_target", v, e.val);
    end
  endtask
  always @(negedge clk) begin
    if (exception) begin
      exc_cyc = cyc;
      pop(2'd0, cause, cp0_pc);
    end
    if (eret) pop(2'd1, 5'd0, 32'd0);
    if (pc_redirect) pop(2'd2, 5'd0, redirect_target);
    if (stall) stall_cyc++;
    if (!rst) run = 0;
    else if (stall) run++;
    else if (run != 0) begin
      check("stall_len", 32'(run), 32'd2);
      run = 0;
    end
  end
  task automatic exp_exc(input logic [4:0] c, input logic [31:0] pc);
    q.push_back({2'd0, c, pc});
    q.push_back({2'd2, 5'd0, VEC});
  endtask
  task automatic exp_ret(input logic [31:0] t);
    q.push_back({2'd1, 5'd0, 32'd0});
    q.push_back({2'd2, 5'd0, t});
  endtask
  task automatic fire(input logic [31:0] pc, input logic s, input logic b, input logic t,
                      input logic te, input logic e, input int hold);
    instr_valid = 1; dec_pc = pc; is_syscall = s; is_break = b; is_teq = t; teq_equal = te; is_eret = e;
    repeat (hold) @(posedge clk);
    #1;
    instr_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_equal = 0; is_eret = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic quiet(input string name);
    int e0, s0;
    e0 = ev_cnt; s0 = stall_cyc;
    fire(32'h0040_0040, is_syscall, 0, 0, 0, 0, 1);
    check({name, "_events"}, 32'(ev_cnt), 32'(e0));
    check({name, "_stall"}, 32'(stall_cyc), 32'(s0));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_exception", 32'(exception), 0);
    check("rst_eret", 32'(eret), 0);
    check("rst_redirect", 32'(pc_redirect), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_cause", 32'(cause), 0);
    check("rst_cp0_pc", cp0_pc, 0);
    check("rst_target", redirect_target, 0);
    rst = 1;
    @(posedge clk); #1;
    status = 32'h0000_000F;
    exp_exc(5'd8, 32'h0040_0020);
    fire(32'h0040_0020, 1, 0, 0, 0, 0, 1);
    status = 32'h0000_000D;
    is_syscall = 1;
    quiet("masked_sys");
    exp_exc(5'd9, 32'h0040_0030);
    fire(32'h0040_0030, 0, 1, 0, 0, 0, 1);
    begin
      int e0;
      e0 = ev_cnt;
      fire(32'h0040_0034, 0, 0, 1, 0, 0, 1);
      check("teq_unequal_events", 32'(ev_cnt), 32'(e0));
    end
    exp_exc(5'd13, 32'h0040_0038);
    fire(32'h0040_0038, 0, 0, 1, 1, 0, 1);
    status = 32'h0000_0000;
    epc_addr = 32'h0040_0024;
    exp_ret(32'h0040_0024);
    fire(32'h0040_0050, 0, 0, 0, 0, 1, 1);
    status = 32'h0000_000F;
    exp_ret(32'h0040_0024);
    fire(32'h0040_0054, 1, 1, 0, 0, 1, 1);
    exp_exc(5'd8, 32'h0040_0058);
    fire(32'h0040_0058, 1, 1, 1, 1, 0, 1);
    exp_exc(5'd8, 32'h0040_0060);
    exp_exc(5'd8, 32'h0040_0060);
    fire(32'h0040_0060, 1, 0, 0, 0, 0, 4);
    status = 32'h0000_0101;
    instr_valid = 1; dec_pc = 32'h0040_0100;
    exp_exc(5'd0, 32'h0040_0100);
    irq = 1; irq_cyc = cyc;
    repeat (3) @(posedge clk);
    #1 irq = 0;
    repeat (6) @(posedge clk);
    #1;
    check("int_latency_ok", 32'(exc_cyc > irq_cyc && exc_cyc - irq_cyc <= 4), 1);
    instr_valid = 0;
    status = 32'h0000_0105;
    instr_valid = 1; dec_pc = 32'h0040_0200;
    exp_exc(5'd9, 32'h0040_0200);
    exp_exc(5'd0, 32'h0040_0200);
    irq = 1;
    repeat (3) @(posedge clk);
    #1 irq = 0; is_break = 1;
    @(posedge clk);
    #1 is_break = 0;
    repeat (8) @(posedge clk);
    #1 instr_valid = 0;
    status = 32'h0000_000F;
    q.push_back({2'd0, 5'd8, 32'h0040_0300});
    instr_valid = 1; dec_pc = 32'h0040_0300; is_syscall = 1;
    @(posedge clk);
    #1 instr_valid = 0; is_syscall = 0; rst = 0;
    @(posedge clk);
    #1;
    check("midrst_exception", 32'(exception), 0);
    check("midrst_redirect", 32'(pc_redirect), 0);
    check("midrst_stall", 32'(stall), 0);
    check("midrst_cause", 32'(cause), 0);
    check("midrst_cp0_pc", cp0_pc, 0);
    check("midrst_target", redirect_target, 0);
    @(posedge clk);
    #1 rst = 1;
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
